// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : pipeline MEM stage - data SRAM response tracking, load
//             extraction, WB handoff and ID forwarding.   Rev 1.0
// ============================================================================
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_to_ms_valid,
  input  logic [76:0] es_to_ms_bus,
  input  logic        es_ex,
  output logic        ms_allowin,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  input  logic        ms_flush,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_to_ws_bus,
  output logic        ms_ex,
  output logic [38:0] ms_rf_zip
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RESP = 2'd1,
    ST_HAVE_DATA = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_valid;
  logic        r_cancel;
  logic        w_cancel_nxt;
  logic [31:0] r_rdata_buf;
  logic        w_buf_load;

  logic        r_mem_req;
  logic        r_ld_b;
  logic        r_ld_bu;
  logic        r_ld_h;
  logic        r_ld_hu;
  logic        r_ld_w;
  logic [31:0] r_pc;
  logic        r_res_from_mem;
  logic        r_rf_we;
  logic [4:0]  r_rf_waddr;
  logic [31:0] r_result;
  logic        r_es_ex;

  logic        w_resp;
  logic        w_ready_go;
  logic        w_allowin;
  logic        w_accept;
  logic [31:0] w_mem_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_final_result;

  assign w_resp     = (r_state == ST_WAIT_RESP) && data_sram_data_ok;
  assign w_ready_go = ~r_mem_req | (r_state == ST_HAVE_DATA) | w_resp;
  // A cancelled request still owes us a data_ok; block new work until it lands.
  assign w_allowin  = ~r_cancel & (~r_valid | (w_ready_go & ws_allowin));
  assign w_accept   = es_to_ms_valid & w_allowin;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
    end else if (ms_flush) begin
      r_valid <= 1'b0;
    end else if (w_allowin) begin
      r_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem_req      <= 1'b0;
      r_ld_b         <= 1'b0;
      r_ld_bu        <= 1'b0;
      r_ld_h         <= 1'b0;
      r_ld_hu        <= 1'b0;
      r_ld_w         <= 1'b0;
      r_pc           <= 32'd0;
      r_res_from_mem <= 1'b0;
      r_rf_we        <= 1'b0;
      r_rf_waddr     <= 5'd0;
      r_result       <= 32'd0;
      r_es_ex        <= 1'b0;
    end else if (w_accept) begin
      r_mem_req      <= es_to_ms_bus[76];
      r_ld_b         <= es_to_ms_bus[75];
      r_ld_bu        <= es_to_ms_bus[74];
      r_ld_h         <= es_to_ms_bus[73];
      r_ld_hu        <= es_to_ms_bus[72];
      r_ld_w         <= es_to_ms_bus[71];
      r_pc           <= es_to_ms_bus[70:39];
      r_res_from_mem <= es_to_ms_bus[38];
      r_rf_we        <= es_to_ms_bus[37];
      r_rf_waddr     <= es_to_ms_bus[36:32];
      r_result       <= es_to_ms_bus[31:0];
      r_es_ex        <= es_ex;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cancel    <= 1'b0;
      r_rdata_buf <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cancel <= w_cancel_nxt;
      if (w_buf_load) begin
        r_rdata_buf <= data_sram_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cancel_nxt = r_cancel;
    w_buf_load   = 1'b0;
    if (r_cancel && data_sram_data_ok) begin
      w_cancel_nxt = 1'b0;
    end
    if (ms_flush) begin
      w_state_nxt = ST_IDLE;
      // A response arriving with the flush is simply consumed here.
      if ((r_state == ST_WAIT_RESP) && !data_sram_data_ok) begin
        w_cancel_nxt = 1'b1;
      end
    end else if (w_allowin) begin
      w_state_nxt = (w_accept && es_to_ms_bus[76]) ? ST_WAIT_RESP : ST_IDLE;
    end else if (w_resp) begin
      w_state_nxt = ST_HAVE_DATA;
      w_buf_load  = 1'b1;
    end
  end

  assign w_mem_word = (r_state == ST_HAVE_DATA) ? r_rdata_buf : data_sram_rdata;

  always_comb begin
    w_byte = w_mem_word[7:0];
    case (r_result[1:0])
      2'd0:    w_byte = w_mem_word[7:0];
      2'd1:    w_byte = w_mem_word[15:8];
      2'd2:    w_byte = w_mem_word[23:16];
      default: w_byte = w_mem_word[31:24];
    endcase
    w_half = r_result[1] ? w_mem_word[31:16] : w_mem_word[15:0];

    w_load_data = w_mem_word;
    if (r_ld_b) begin
      w_load_data = {{24{w_byte[7]}}, w_byte};
    end else if (r_ld_bu) begin
      w_load_data = {24'd0, w_byte};
    end else if (r_ld_h) begin
      w_load_data = {{16{w_half[15]}}, w_half};
    end else if (r_ld_hu) begin
      w_load_data = {16'd0, w_half};
    end else if (r_ld_w) begin
      w_load_data = w_mem_word;
    end
  end

  assign w_final_result = r_res_from_mem ? w_load_data : r_result;

  assign ms_allowin     = w_allowin;
  assign ms_to_ws_valid = r_valid & w_ready_go & ~ms_flush;
  assign ms_to_ws_bus   = {r_pc, r_rf_we, r_rf_waddr, w_final_result};
  assign ms_ex          = r_valid & r_es_ex;
  assign ms_rf_zip      = {r_valid & r_res_from_mem & ~w_ready_go,
                           r_rf_we & r_valid, r_rf_waddr, w_final_result};

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single pipeline clock; all state updates on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 es_to_ms_valid  input  1  EXE presents a valid instruction (EXE MEM_signal_valid AND EXE_readygo).
REQ-005 es_to_ms_bus  input  77  {mem_req[76], ld_b[75], ld_bu[74], ld_h[73], ld_hu[72], ld_w[71], pc[70:39], res_from_mem[38], rf_we[37], rf_waddr[36:32], result[31:0]}.
REQ-006 es_ex  input  1  EXE instruction carries any exception or ertn.
REQ-007 ms_allowin  output  1  MEM accepts a new instruction this cycle.
REQ-008 data_sram_data_ok  input  1  data SRAM read/write response strobe.
REQ-009 data_sram_rdata  input  32  data SRAM read data, valid when data_ok is high.
REQ-010 ws_allowin  input  1  WB accepts an instruction.
REQ-011 ms_flush  input  1  exception/ertn flush from WB.
REQ-012 ms_to_ws_valid  output  1  MEM hands an instruction to WB.
REQ-013 ms_to_ws_bus  output  70  {pc[69:38], rf_we[37], rf_waddr[36:32], final_result[31:0]}.
REQ-014 ms_ex  output  1  to EXE as MEM_to_EXE_excep.
REQ-015 ms_rf_zip  output  39  {ld_wait[38], rf_we & ms_valid[37], rf_waddr[36:32], final_result[31:0]} forwarding/interlock to ID.

Function
REQ-016 ms_valid SHALL load es_to_ms_valid when ms_allowin is high, and clear on ms_flush.
REQ-017 The bus and es_ex SHALL be latched only when es_to_ms_valid && ms_allowin.
REQ-018 State: WAIT_RESP (mem_req latched and response not yet received), HAVE_DATA (response received; rdata buffered), IDLE (all other cases).
REQ-019 ms_ready_go SHALL be 1 when ~mem_req, or in HAVE_DATA, or when data_sram_data_ok arrives in WAIT_RESP.
REQ-020 ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin); ms_to_ws_valid = ms_valid & ms_ready_go & ~ms_flush.
REQ-021 A data_ok that arrives while ws_allowin=0 SHALL capture rdata into a 32-bit buffer and move the block to HAVE_DATA; the buffer SHALL be used until the instruction leaves the stage.
REQ-022 Load data SHALL be selected by result[1:0] as follows:
- ld_b/ld_bu: byte 0-3, sign- or zero-extended.
- ld_h/ld_hu: halfword at result[1] (0 = [15:0], 1 = [31:16]), sign- or zero-extended.
- ld_w: full word.
REQ-023 final_result SHALL be the extended load data when res_from_mem is set, and result otherwise.
REQ-024 ms_ex SHALL equal ms_valid & es_ex_latched.
REQ-025 ld_wait SHALL equal ms_valid & res_from_mem & ~ms_ready_go.
REQ-026 Flush while in WAIT_RESP SHALL set a 1-bit cancel flag. The next data_ok SHALL be discarded and SHALL clear the flag. While the flag is set, a newly accepted instruction SHALL NOT treat that data_ok as its own.
REQ-027 The cancel flag SHALL hold ms_allowin low until the discarded data_ok is seen, so that at most one response is outstanding.
REQ-028 If data_ok and ms_flush arrive in the same cycle, the response SHALL be consumed, the cancel flag SHALL stay clear, and the instruction SHALL be dropped.
REQ-029 When mem_req=0 (stores/loads suppressed by an exception), the instruction SHALL pass in one cycle with no SRAM wait.
REQ-030 A store (mem_req=1, res_from_mem=0) SHALL still wait for data_ok.

Reset
REQ-031 On resetn low, the following SHALL clear asynchronously: ms_valid, state (IDLE), cancel flag, rdata buffer, and all latched bus fields.
REQ-032 While resetn is low, every output SHALL be 0 except ms_allowin=1.
REQ-033 Reset during WAIT_RESP SHALL abandon the request with no cancel pending.

Verification
REQ-034 ld_w, result=0x1000, mem_req=1, ws_allowin=1; data_ok with rdata=0xDEADBEEF 2 cycles later -> ms_to_ws_valid for 1 cycle, final_result=0xDEADBEEF, ld_wait high during the wait.
REQ-035 ld_b, result[1:0]=2'b11, rdata=0x80123456 -> final_result=0xFFFFFF80; the same case with ld_bu -> 0x00000080; ld_hu with result[1]=1 -> 0x00008012.
REQ-036 Load data_ok arrives with ws_allowin=0 for 3 cycles -> state HAVE_DATA, buffer holds the rdata, data is forwarded unchanged when ws_allowin rises.
REQ-037 ms_flush in WAIT_RESP; a new load accepted; first data_ok (rdata=0x11111111) discarded; second data_ok (rdata=0x22222222) -> final_result=0x22222222.
REQ-038 ALU op with mem_req=0, result=0x5 -> ms_to_ws_valid the cycle after acceptance, final_result=0x5; es_ex=1 -> ms_ex=1 while valid.
REQ-039 resetn asserted mid-WAIT_RESP -> all outputs 0 and ms_allowin=1 immediately, without a clock edge.
